// File: rtl/vga_timing_gen_if.sv
// Pixel/scan bundle shared between the timing generator and the sprite renderers.
// The generator drives it through the master modport; renderers listen through slave.
interface vga_timing_gen_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       h_sync;
  logic       v_sync;
  logic       video_on;
  logic       frame_start;

  modport master (
    output p_tick, pix_x, pix_y, h_sync, v_sync, video_on, frame_start
  );

  modport slave (
    input p_tick, pix_x, pix_y, h_sync, v_sync, video_on, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan timing source: pixel strobe, scan coordinates, syncs, blanking and frame pulse.
// All flags are registered from the next-count values, so they line up with pix_x/pix_y.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Coordinates are 10 bits wide, so neither total may exceed 1024.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             frame_wrap;
  logic             h_sync_next;
  logic             v_sync_next;
  logic             video_on_next;

  always_comb begin
    div_next      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    x_next        = vga.pix_x;
    y_next        = vga.pix_y;
    frame_wrap    = 1'b0;
    if (vga.p_tick) begin
      if (vga.pix_x == H_LAST) begin
        x_next = '0;
        if (vga.pix_y == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = vga.pix_y + 10'd1;
        end
      end else begin
        x_next = vga.pix_x + 10'd1;
      end
    end
    h_sync_next   = ((x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    v_sync_next   = ((y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Flags only reload on a pixel step, which keeps video_on low until the first strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q           <= '0;
      vga.p_tick      <= 1'b0;
      vga.pix_x       <= '0;
      vga.pix_y       <= '0;
      vga.h_sync      <= ~SYNC_POL;
      vga.v_sync      <= ~SYNC_POL;
      vga.video_on    <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      div_q           <= div_next;
      vga.p_tick      <= (div_next == DIV_LAST);
      vga.frame_start <= frame_wrap;
      if (vga.p_tick) begin
        vga.pix_x    <= x_next;
        vga.pix_y    <= y_next;
        vga.h_sync   <= h_sync_next;
        vga.v_sync   <= v_sync_next;
        vga.video_on <= video_on_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for reset/line checks, plus a tiny
// CLK_DIV=1 / active-high instance whose whole frames fit in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 clk = ~clk;

  vga_timing_gen_if vga0 ();
  vga_timing_gen_if vga1 ();

  vga_timing_gen dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .vga   (vga0)
  );

  // Small frame: H_TOTAL=15 (sync x 10..12), V_TOTAL=9 (sync lines 5..6), 135 clks per frame.
  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .CLK_DIV   (1), .SYNC_POL (1'b1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .vga   (vga1)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to clock edge number 'target' since release and sample 2 ns later.
  task automatic run_to(input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #2;
  endtask

  initial begin
    int fs_cnt, fs1, fs2, hs1, vs1, vo1, pt1, pt0, base, fs_first;
    int pt_line, hs_low, vo_line, fs_line;

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_output("rst_pix_x", 32'(vga0.pix_x), 0);
    check_output("rst_pix_y", 32'(vga0.pix_y), 0);
    check_output("rst_h_sync", 32'(vga0.h_sync), 1);
    check_output("rst_v_sync", 32'(vga0.v_sync), 1);
    check_output("rst_video_on", 32'(vga0.video_on), 0);
    check_output("rst_p_tick", 32'(vga0.p_tick), 0);
    check_output("rst_frame_start", 32'(vga0.frame_start), 0);
    check_output("rst1_h_sync", 32'(vga1.h_sync), 0);
    check_output("rst1_v_sync", 32'(vga1.v_sync), 0);

    rst0_n = 1'b1;
    rst1_n = 1'b1;
    e = 0;

    run_to(1);
    check_output("e1_p_tick", 32'(vga0.p_tick), 1);
    check_output("e1_pix_x", 32'(vga0.pix_x), 0);
    check_output("e1_video_on", 32'(vga0.video_on), 0);
    check_output("e1_p_tick_div1", 32'(vga1.p_tick), 1);
    check_output("e1_video_on_div1", 32'(vga1.video_on), 0);

    run_to(2);
    check_output("e2_p_tick", 32'(vga0.p_tick), 0);
    check_output("e2_pix_x", 32'(vga0.pix_x), 1);
    check_output("e2_video_on", 32'(vga0.video_on), 1);
    check_output("e2_pix_x_div1", 32'(vga1.pix_x), 1);

    fs_cnt = 0; fs1 = 0; fs2 = 0; hs1 = 0; vs1 = 0; vo1 = 0; pt1 = 0; pt0 = 0;
    for (int k = 2; k <= 271; k++) begin
      run_to(k);
      if (vga1.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 1) fs1 = e;
        else fs2 = e;
      end
      if (vga1.h_sync === 1'b1) hs1++;
      if (vga1.v_sync === 1'b1) vs1++;
      if (vga1.video_on === 1'b1) vo1++;
      if (vga1.p_tick === 1'b1) pt1++;
      if (vga0.p_tick === 1'b1) pt0++;
    end
    check_output("div1_frame_pulses", 32'(fs_cnt), 2);
    check_output("div1_first_frame_edge", 32'(fs1), 136);
    check_output("div1_second_frame_edge", 32'(fs2), 271);
    check_output("div1_h_sync_high_clks", 32'(hs1), 54);
    check_output("div1_v_sync_high_clks", 32'(vs1), 60);
    check_output("div1_video_on_clks", 32'(vo1), 64);
    check_output("div1_p_tick_clks", 32'(pt1), 270);
    check_output("div2_p_tick_clks", 32'(pt0), 135);
    check_output("div1_wrap_x", 32'(vga1.pix_x), 0);
    check_output("div1_wrap_y", 32'(vga1.pix_y), 0);

    run_to(306);
    check_output("mid_pix_x", 32'(vga1.pix_x), 5);
    check_output("mid_pix_y", 32'(vga1.pix_y), 2);
    check_output("mid_video_on", 32'(vga1.video_on), 1);
    rst1_n = 1'b0;
    #1;
    check_output("async_pix_x", 32'(vga1.pix_x), 0);
    check_output("async_pix_y", 32'(vga1.pix_y), 0);
    check_output("async_p_tick", 32'(vga1.p_tick), 0);
    check_output("async_video_on", 32'(vga1.video_on), 0);
    run_to(308);
    check_output("held_frame_start", 32'(vga1.frame_start), 0);
    check_output("held_p_tick", 32'(vga1.p_tick), 0);
    rst1_n = 1'b1;
    base = 308;
    fs_first = 0;
    for (int r = 1; r <= 140; r++) begin
      run_to(base + r);
      if (vga1.frame_start === 1'b1 && fs_first == 0) fs_first = r;
      if (r == 1) check_output("restart_pix_x", 32'(vga1.pix_x), 0);
      if (r == 10) check_output("restart_h_sync_x9", 32'(vga1.h_sync), 0);
      if (r == 11) check_output("restart_h_sync_x10", 32'(vga1.h_sync), 1);
      if (r == 75) check_output("restart_v_sync_line4", 32'(vga1.v_sync), 0);
      if (r == 76) check_output("restart_v_sync_line5", 32'(vga1.v_sync), 1);
    end
    check_output("restart_first_frame_edge", 32'(fs_first), 136);

    run_to(1278);
    check_output("x639_video_on", 32'(vga0.video_on), 1);
    run_to(1280);
    check_output("x640_pix_x", 32'(vga0.pix_x), 640);
    check_output("x640_video_on", 32'(vga0.video_on), 0);
    run_to(1310);
    check_output("x655_h_sync", 32'(vga0.h_sync), 1);
    run_to(1312);
    check_output("x656_h_sync", 32'(vga0.h_sync), 0);
    run_to(1502);
    check_output("x751_h_sync", 32'(vga0.h_sync), 0);
    run_to(1504);
    check_output("x752_h_sync", 32'(vga0.h_sync), 1);
    run_to(1599);
    check_output("x799_pix_x", 32'(vga0.pix_x), 799);
    check_output("x799_pix_y", 32'(vga0.pix_y), 0);
    run_to(1600);
    check_output("line1_pix_x", 32'(vga0.pix_x), 0);
    check_output("line1_pix_y", 32'(vga0.pix_y), 1);
    check_output("line1_video_on", 32'(vga0.video_on), 1);

    pt_line = 0; hs_low = 0; vo_line = 0; fs_line = 0;
    for (int k = 1600; k <= 3199; k++) begin
      run_to(k);
      if (vga0.p_tick === 1'b1) pt_line++;
      if (vga0.h_sync === 1'b0) hs_low++;
      if (vga0.video_on === 1'b1) vo_line++;
      if (vga0.frame_start === 1'b1) fs_line++;
    end
    check_output("line_p_ticks", 32'(pt_line), 800);
    check_output("line_h_sync_low_clks", 32'(hs_low), 192);
    check_output("line_video_on_clks", 32'(vo_line), 1280);
    check_output("line_frame_pulses", 32'(fs_line), 0);
    run_to(3200);
    check_output("line2_pix_y", 32'(vga0.pix_y), 2);
    check_output("line2_pix_x", 32'(vga0.pix_x), 0);
    check_output("line2_v_sync", 32'(vga0.v_sync), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
